heap_topk_reader: RTL
=====================

# heap_topk_reader

Read-side controller for the hot-page max-heap. On a software/CSR request it drains the top-K (count, address) entries from the heap via its query port, one outstanding query at a time. Results are buffered and streamed to a downstream consumer over a valid/ready interface. It sits between the heap and the hot-page report path, opposite the sketch-side feeder that drives `input_valid`/`input_cnt`/`input_addr`.

## Interface
Parameters:
- `CNT_SIZE`, 20, count field width
- `ADDR_SIZE`, 28, address field width
- `TOTAL_LEVEL`, 6, heap depth; capacity = 2**TOTAL_LEVEL-1 entries
- `FIFO_DEPTH`, 8, output buffer entries (power of two, ≥2)

Ports:
- `clk`  in  1  sole clock
- `rst_n`  in  1  asynchronous, active-low reset
- `req_start`  in  1  one-cycle start pulse; sampled only in IDLE
- `req_k`  in  TOTAL_LEVEL+1  number of entries requested
- `busy`  out  1  high from accepted start until `done`
- `done`  out  1  one-cycle pulse; drain finished and buffer emptied
- `heap_hold`  out  1  equals `busy`; feeder must not insert while high
- `heap_query`  out  1  one-cycle pop request to heap
- `heap_rsp_valid`  in  1  heap response strobe
- `heap_rsp_cnt`  in  CNT_SIZE  popped count
- `heap_rsp_addr`  in  ADDR_SIZE  popped address
- `heap_rsp_last`  in  1  with valid: popped entry left heap empty
- `heap_rsp_empty`  in  1  with valid: heap already empty, no data carried
- `out_valid`, `out_ready`  out/in  1  output handshake
- `out_cnt`, `out_addr`  out  CNT_SIZE/ADDR_SIZE  entry
- `out_last`  out  1  final entry of this drain
- `err`  out  1  sticky error (see Configuration)

## Operation
- FSM: IDLE → QUERY → WAIT → (QUERY | FLUSH) → IDLE.
- IDLE: `req_start`=1 latches `req_k` into `remaining`. If `req_k`=0, go to FLUSH; otherwise go to QUERY.
- QUERY: assert `heap_query` for exactly one cycle, only when FIFO occupancy < FIFO_DEPTH; otherwise stall in QUERY. Then go to WAIT.
- WAIT: on `heap_rsp_valid`:
  - If `heap_rsp_empty`: go to FLUSH. No write; the previous entry already carries last.
  - Else: write {cnt, addr, last} into the FIFO, with last = (`remaining`==1) | `heap_rsp_last`. Decrement `remaining`. Go to FLUSH if last, else QUERY.
- FLUSH: wait for the FIFO to be empty, then pulse `done` and return to IDLE.
- Entries stream in heap pop order, i.e. non-increasing count.
- `heap_rsp_valid` outside WAIT is ignored.
- `req_start` while busy is ignored.
- Reset mid-drain: FSM → IDLE, FIFO flushed, all outputs cleared. Heap contents already popped are lost.

## Timing
- Reset values: `busy`, `done`, `heap_hold`, `heap_query`, `out_valid`, `out_last`, `err` = 0. `out_cnt` and `out_addr` = 0.
- `heap_query` is asserted the cycle after `req_start` is accepted, given FIFO space.
- At most one query is outstanding. Heap response latency is ≥1 cycle and unbounded.
- FIFO write occurs on the `heap_rsp_valid` cycle. `out_valid` rises the following cycle (registered FIFO output).
- Handshake: transfer when `out_valid & out_ready`. `out_*` hold stable while `out_valid & !out_ready`.
- Simultaneous FIFO write and read when full is not possible, because a query requires space.
- Simultaneous write and read when empty: the new entry is visible the next cycle.
- `done` fires the cycle after the last handshake, or 1 cycle after FLUSH entry if the FIFO is already empty.

## Configuration
- `HEAP_READER_TIMEOUT_EN` defined: a 6-bit watchdog counts cycles in WAIT. After 64 cycles without `heap_rsp_valid`, set `err` and go to FLUSH. `err` clears only on reset or an accepted `req_start`.
- Undefined: no watchdog; `err` is tied 0; WAIT waits indefinitely.

## Structure
- `heap_pkg`: `heap_entry_t` {cnt, addr}, reader state enum, and the timeout constant 64.
- Sub-module `heap_rd_fifo`: synchronous FIFO of {heap_entry_t, last}, with count, full, and empty outputs.

## Test plan
- Insert 7/107, 6/106, 11/111, 5/105, 8/108; `req_k`=3 → outputs 11/111, 8/108, 7/107; `out_last` on the third; `done` once.
- Same 5 entries, `req_k`=8 → 5 outputs in order 11, 8, 7, 6, 5; last on 5/105 via `heap_rsp_last`; no 6th query.
- Empty heap, `req_k`=4 → one query, `heap_rsp_empty` response, zero outputs, `done` pulse.
- `req_k`=0 → no `heap_query`; `done` 2 cycles after start.
- 12 inserted entries, `req_k`=12, `out_ready` low for 40 cycles:
  - queries stop after 8 buffered entries;
  - on release, all 12 arrive in order 28, 18, 17, 12, 11, 10, 8, 7, 6, 5, 3, 2.
- With `HEAP_READER_TIMEOUT_EN`, heap never responds → `err`=1 at 64 cycles and `done`. Reset asserted mid-drain → all outputs 0, FSM returns to IDLE.

Source files
------------

// File: rtl/heap_pkg.sv
// heap_pkg: shared types and constants for the hot-page heap read path.
// Holds the default entry layout, the reader FSM state encoding and the
// watchdog length used when HEAP_READER_TIMEOUT_EN is defined.
package heap_pkg;

  localparam int HEAP_CNT_W  = 20;
  localparam int HEAP_ADDR_W = 28;

  // One heap slot at the default field widths.
  typedef struct packed {
    logic [HEAP_CNT_W-1:0]  cnt;
    logic [HEAP_ADDR_W-1:0] addr;
  } heap_entry_t;

  // Reader FSM state encoding, kept as plain constants for legacy tooling.
  typedef logic [1:0] rd_state_t;
  localparam rd_state_t RD_IDLE  = 2'd0;
  localparam rd_state_t RD_QUERY = 2'd1;
  localparam rd_state_t RD_WAIT  = 2'd2;
  localparam rd_state_t RD_FLUSH = 2'd3;

  // Silent WAIT cycles tolerated before the watchdog gives up.
  localparam int         RD_TIMEOUT_CYCLES = 64;
  localparam logic [5:0] RD_WDOG_LAST      = 6'(RD_TIMEOUT_CYCLES - 1);

  // A popped entry closes the drain when it is the K-th one requested or
  // when the heap reports it had nothing left behind it.
  function automatic logic entry_is_last(input logic rem_is_one,
                                         input logic rsp_last);
    return rem_is_one | rsp_last;
  endfunction

endpackage

// File: rtl/heap_rd_fifo.sv
// heap_rd_fifo: small synchronous FIFO holding {cnt, addr, last} words
// between the heap response port and the downstream consumer.
// The head word is presented directly from the storage registers and is
// forced to zero while the FIFO is empty.
module heap_rd_fifo
  import heap_pkg::*;
#(
  parameter int CNT_W  = HEAP_CNT_W,
  parameter int ADDR_W = HEAP_ADDR_W,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [CNT_W-1:0]         wr_cnt,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic                     wr_last,
  input  logic                     rd_en,
  output logic [CNT_W-1:0]         rd_cnt,
  output logic [ADDR_W-1:0]        rd_addr,
  output logic                     rd_last,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int                PTR_W    = $clog2(DEPTH);
  localparam int                WORD_W   = CNT_W + ADDR_W + 1;
  localparam logic [PTR_W:0]    LVL_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]    LVL_ZERO = {(PTR_W + 1){1'b0}};
  localparam logic [PTR_W:0]    LVL_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);

  logic [WORD_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W:0]    count_r;
  logic              do_wr_s;
  logic              do_rd_s;
  logic [WORD_W-1:0] head_s;

  assign full    = (count_r == LVL_FULL);
  assign empty   = (count_r == LVL_ZERO);
  assign count   = count_r;
  assign do_wr_s = wr_en & ~full;
  assign do_rd_s = rd_en & ~empty;

  // Storage array: write the incoming word at the tail slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WORD_W{1'b0}};
      end
    end else if (do_wr_s) begin
      mem_r[wr_ptr_r] <= {wr_cnt, wr_addr, wr_last};
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is 2**n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= LVL_ZERO;
    end else begin
      if (do_wr_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_rd_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_wr_s, do_rd_s})
        2'b10:   count_r <= count_r + LVL_ONE;
        2'b01:   count_r <= count_r - LVL_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Head-of-queue view, zeroed while nothing is buffered.
  always_comb begin
    head_s  = mem_r[rd_ptr_r];
    rd_cnt  = {CNT_W{1'b0}};
    rd_addr = {ADDR_W{1'b0}};
    rd_last = 1'b0;
    if (!empty) begin
      rd_cnt  = head_s[WORD_W-1 -: CNT_W];
      rd_addr = head_s[ADDR_W:1];
      rd_last = head_s[0];
    end else begin
      rd_cnt  = {CNT_W{1'b0}};
      rd_addr = {ADDR_W{1'b0}};
      rd_last = 1'b0;
    end
  end

endmodule

// File: rtl/heap_topk_reader.sv
// heap_topk_reader: on request, pops the top-K (count, address) entries
// from the hot-page max-heap one query at a time and streams them to the
// report path over valid/ready, marking the final entry with out_last.
// Optional feature macro: HEAP_READER_TIMEOUT_EN enables a WAIT-state
// watchdog that raises the sticky err flag after 64 silent cycles.
module heap_topk_reader
  import heap_pkg::*;
#(
  parameter int CNT_SIZE    = 20,
  parameter int ADDR_SIZE   = 28,
  parameter int TOTAL_LEVEL = 6,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_start,
  input  logic [TOTAL_LEVEL:0]   req_k,
  output logic                   busy,
  output logic                   done,
  output logic                   heap_hold,
  output logic                   heap_query,
  input  logic                   heap_rsp_valid,
  input  logic [CNT_SIZE-1:0]    heap_rsp_cnt,
  input  logic [ADDR_SIZE-1:0]   heap_rsp_addr,
  input  logic                   heap_rsp_last,
  input  logic                   heap_rsp_empty,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CNT_SIZE-1:0]    out_cnt,
  output logic [ADDR_SIZE-1:0]   out_addr,
  output logic                   out_last,
  output logic                   err
);

  localparam int                REM_W     = TOTAL_LEVEL + 1;
  localparam int                FCNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [REM_W-1:0]  REM_ZERO  = {REM_W{1'b0}};
  localparam logic [REM_W-1:0]  REM_ONE   = REM_W'(1);
  localparam logic [FCNT_W-1:0] FCNT_ZERO = {FCNT_W{1'b0}};
  localparam logic [FCNT_W-1:0] FCNT_ONE  = FCNT_W'(1);
  localparam logic [FCNT_W-1:0] FCNT_FULL = FCNT_W'(FIFO_DEPTH);

  rd_state_t          state_r;
  rd_state_t          state_nxt_s;
  logic [REM_W-1:0]   remaining_r;
  logic               busy_r;
  logic               done_r;
  logic               query_r;
  logic               start_ok_s;
  logic               fifo_wr_s;
  logic               fifo_rd_s;
  logic               wr_last_s;
  logic               wdog_hit_s;
  logic               out_valid_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic               space_nxt_s;
  logic [FCNT_W-1:0]  fifo_count_s;
  logic [FCNT_W-1:0]  fifo_cnt_nxt_s;

  assign start_ok_s  = (state_r == RD_IDLE) & req_start;
  assign out_valid_s = ~fifo_empty_s;
  assign fifo_rd_s   = out_valid_s & out_ready;

  assign busy       = busy_r;
  assign heap_hold  = busy_r;
  assign done       = done_r;
  assign heap_query = query_r;
  assign out_valid  = out_valid_s;

  heap_rd_fifo #(
    .CNT_W  (CNT_SIZE),
    .ADDR_W (ADDR_SIZE),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (fifo_wr_s),
    .wr_cnt  (heap_rsp_cnt),
    .wr_addr (heap_rsp_addr),
    .wr_last (wr_last_s),
    .rd_en   (fifo_rd_s),
    .rd_cnt  (out_cnt),
    .rd_addr (out_addr),
    .rd_last (out_last),
    .count   (fifo_count_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

`ifdef HEAP_READER_TIMEOUT_EN
  logic [5:0] wdog_r;
  logic       err_r;

  assign wdog_hit_s = (state_r == RD_WAIT) & ~heap_rsp_valid &
                      (wdog_r == RD_WDOG_LAST);
  assign err        = err_r;

  // Count consecutive WAIT cycles with no heap response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_r <= 6'd0;
    end else if ((state_r == RD_WAIT) && !heap_rsp_valid) begin
      wdog_r <= wdog_r + 6'd1;
    end else begin
      wdog_r <= 6'd0;
    end
  end

  // Sticky timeout flag, cleared by the next accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (start_ok_s) begin
      err_r <= 1'b0;
    end else if (wdog_hit_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end
`else
  assign wdog_hit_s = 1'b0;
  assign err        = 1'b0;
`endif

  // Decode a FIFO write from a data-carrying heap response in WAIT.
  always_comb begin
    fifo_wr_s = 1'b0;
    wr_last_s = 1'b0;
    if ((state_r == RD_WAIT) && heap_rsp_valid && !heap_rsp_empty &&
        !fifo_full_s) begin
      fifo_wr_s = 1'b1;
      wr_last_s = entry_is_last(remaining_r == REM_ONE, heap_rsp_last);
    end else begin
      fifo_wr_s = 1'b0;
      wr_last_s = 1'b0;
    end
  end

  // Occupancy after this cycle's push/pop, used to gate the next query.
  always_comb begin
    fifo_cnt_nxt_s = fifo_count_s;
    case ({fifo_wr_s, fifo_rd_s})
      2'b10:   fifo_cnt_nxt_s = fifo_count_s + FCNT_ONE;
      2'b01:   fifo_cnt_nxt_s = fifo_count_s - FCNT_ONE;
      default: fifo_cnt_nxt_s = fifo_count_s;
    endcase
    space_nxt_s = (fifo_cnt_nxt_s < FCNT_FULL);
  end

  // Reader FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RD_IDLE: begin
        if (req_start) begin
          state_nxt_s = (req_k == REM_ZERO) ? RD_FLUSH : RD_QUERY;
        end else begin
          state_nxt_s = RD_IDLE;
        end
      end
      RD_QUERY: begin
        if (query_r) begin
          state_nxt_s = RD_WAIT;
        end else begin
          state_nxt_s = RD_QUERY;
        end
      end
      RD_WAIT: begin
        if (heap_rsp_valid) begin
          if (heap_rsp_empty || wr_last_s) begin
            state_nxt_s = RD_FLUSH;
          end else begin
            state_nxt_s = RD_QUERY;
          end
        end else if (wdog_hit_s) begin
          state_nxt_s = RD_FLUSH;
        end else begin
          state_nxt_s = RD_WAIT;
        end
      end
      RD_FLUSH: begin
        if (fifo_cnt_nxt_s == FCNT_ZERO) begin
          state_nxt_s = RD_IDLE;
        end else begin
          state_nxt_s = RD_FLUSH;
        end
      end
      default: state_nxt_s = RD_IDLE;
    endcase
  end

  // FSM state, entry budget and the registered control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= RD_IDLE;
      remaining_r <= REM_ZERO;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      query_r     <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      // The query strobe is high for exactly the QUERY cycle that has room.
      query_r <= (state_nxt_s == RD_QUERY) & space_nxt_s;
      done_r  <= (state_r == RD_FLUSH) & (state_nxt_s == RD_IDLE);
      if (start_ok_s) begin
        remaining_r <= req_k;
      end else if (fifo_wr_s) begin
        remaining_r <= remaining_r - REM_ONE;
      end else begin
        remaining_r <= remaining_r;
      end
      if (start_ok_s) begin
        busy_r <= 1'b1;
      end else if ((state_r == RD_FLUSH) && (state_nxt_s == RD_IDLE)) begin
        busy_r <= 1'b0;
      end else begin
        busy_r <= busy_r;
      end
    end
  end

endmodule
